seven_segment_scan: RTL

// - Parametrised N-digit seven-segment scan driver; successor to the fixed 4-digit scanner.
// - Time-multiplexes DIGITS digits: integrated refresh divider, frame-buffered (tear-free) input,
//   per-digit decimal point, per-digit blanking, 16-level PWM brightness.
// - Sits between game/score logic (packed 7-bit segment codes) and board anode/cathode pins.

---
 rtl/seven_segment_scan.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seven_segment_scan.sv
// N-digit seven-segment scan driver: refresh divider, tear-free frame buffer, dp/blank masks, PWM brightness.
// Optional blink feature enabled by defining SSEG_BLINK_EN.
module seven_segment_scan #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned DIV_BITS   = 12,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7*DIGITS-1:0]   display_queue,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [3:0]            brightness,
`ifdef SSEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [DIGITS-1:0]     digit_select,
  output logic [6:0]            display_select,
  output logic                  dp,
  output logic                  frame_sync
);

  localparam int unsigned STEP_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int unsigned SEG_W  = 7 * DIGITS;

  if (DIGITS < 2) begin : g_bad_digits
    $error("DIGITS must be >= 2");
  end
  if (DIV_BITS < 4) begin : g_bad_div
    $error("DIV_BITS must be >= 4");
  end
  if (BLINK_BITS < 1) begin : g_bad_blink
    $error("BLINK_BITS must be >= 1");
  end

  logic [DIV_BITS-1:0] div_cnt;
  logic [STEP_W-1:0]   step;
  logic [SEG_W-1:0]    frame_seg;
  logic [DIGITS-1:0]   frame_dp;
  logic [DIGITS-1:0]   frame_blank;
`ifdef SSEG_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt;
  logic [DIGITS-1:0]     frame_blink;
  logic                  slot_blink;
`endif

  logic              tick;
  logic              last;
  logic              load;
  logic              pwm_on;
  logic              blink_on;
  logic              lit;
  logic [6:0]        slot_seg;
  logic              slot_blank;
  logic              slot_dp;
  logic [DIGITS-1:0] slot_sel;
  logic [DIGITS-1:0] next_digit_select;
  logic [6:0]        next_display_select;
  logic              next_dp;

  assign tick   = &div_cnt;
  assign last   = (step == STEP_W'(DIGITS - 1));
  assign load   = tick & last;
  assign pwm_on = (div_cnt[DIV_BITS-1 -: 4] <= brightness);

  // Select the frame data belonging to the current slot (slot k drives digit bit DIGITS-1-k).
  always_comb begin
    slot_seg   = 7'h7F;
    slot_blank = 1'b1;
    slot_dp    = 1'b0;
    slot_sel   = '1;
`ifdef SSEG_BLINK_EN
    slot_blink = 1'b0;
`endif
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (step == STEP_W'(k)) begin
        slot_seg   = frame_seg[7*(int'(DIGITS)-k)-1 -: 7];
        slot_blank = frame_blank[int'(DIGITS)-1-k];
        slot_dp    = frame_dp[int'(DIGITS)-1-k];
        slot_sel   = ~(DIGITS'(1) << (int'(DIGITS)-1-k));
`ifdef SSEG_BLINK_EN
        slot_blink = frame_blink[int'(DIGITS)-1-k];
`endif
      end
    end
  end

`ifdef SSEG_BLINK_EN
  assign blink_on = ~(slot_blink & blink_cnt[BLINK_BITS-1]);
`else
  assign blink_on = 1'b1;
`endif

  assign lit = pwm_on & ~slot_blank & blink_on;

  always_comb begin
    next_digit_select   = '1;
    next_display_select = 7'h7F;
    next_dp             = 1'b1;
    if (lit) begin
      next_digit_select   = slot_sel;
      next_display_select = slot_seg;
      next_dp             = ~slot_dp;
    end
  end

  // Scan counters, frame buffer and registered pin drivers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt        <= '0;
      step           <= '0;
      frame_seg      <= '1;
      frame_dp       <= '0;
      frame_blank    <= '1;
      digit_select   <= '1;
      display_select <= 7'h7F;
      dp             <= 1'b1;
      frame_sync     <= 1'b0;
    end else begin
      div_cnt        <= div_cnt + DIV_BITS'(1);
      frame_sync     <= load;
      digit_select   <= next_digit_select;
      display_select <= next_display_select;
      dp             <= next_dp;
      if (tick) begin
        step <= last ? '0 : step + STEP_W'(1);
      end
      if (load) begin
        frame_seg   <= display_queue;
        frame_dp    <= dp_mask;
        frame_blank <= blank_mask;
      end
    end
  end

`ifdef SSEG_BLINK_EN
  // Blink counter and the blink bits of the frame buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      frame_blink <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_BITS'(1);
      if (load) begin
        frame_blink <= blink_mask;
      end
    end
  end
`endif

endmodule
